// File: rtl/pic_pkg.sv
// pic_pkg: shared types and constants for the 8259A-style interrupt scheduler.
//   ack_state_e : INTA handshake state (encoding is visible on ack_state).
//   OCW2 command codes decoded from ocw2[7:5] (R, SL, EOI).
//   id2mask     : one-hot mask for a 3-bit IR id.
package pic_pkg;

  localparam int NUM_IR  = 8;
  localparam int IR_ID_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACK1 = 2'b01,
    ST_ACK2 = 2'b11
  } ack_state_e;

  localparam logic [2:0] ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] NS_EOI       = 3'b001;
  localparam logic [2:0] SP_EOI       = 3'b011;
  localparam logic [2:0] ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] SET_PRIO     = 3'b110;
  localparam logic [2:0] ROT_SP_EOI   = 3'b111;

  function automatic logic [NUM_IR-1:0] id2mask(input logic [IR_ID_W-1:0] id);
    logic [NUM_IR-1:0] one;
    one = {{(NUM_IR-1){1'b0}}, 1'b1};
    return one << id;
  endfunction

endpackage

// File: rtl/pic_prio_find.sv
// pic_prio_find: rotating priority encoder.
//   req_i   [7:0] request vector
//   lp_i    [2:0] lowest-priority IR; search starts at lp_i+1 and wraps
//   found_o       at least one request bit set
//   id_o    [2:0] highest-priority set bit (0 when none)
module pic_prio_find
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0]  req_i,
  input  logic [IR_ID_W-1:0] lp_i,
  output logic               found_o,
  output logic [IR_ID_W-1:0] id_o
);

  always_comb begin
    found_o = 1'b0;
    id_o    = '0;
    for (int k = 0; k < NUM_IR; k++) begin
      logic [IR_ID_W-1:0] idx;
      idx = lp_i + IR_ID_W'(k + 1);
      if (!found_o && req_i[idx]) begin
        found_o = 1'b1;
        id_o    = idx;
      end
    end
  end

endmodule

// File: rtl/pic_irq_scheduler.sv
// pic_irq_scheduler: IRR/ISR holding, rotating-priority resolution, INT
// generation, two-pulse INTA sequencing and OCW2 EOI/rotate execution.
//   clk, rst        clock, synchronous active-high reset
//   ir[7:0]         synchronized request lines; imr[7:0] mask (1 = masked)
//   ltim            1 = level-triggered, 0 = edge-triggered
//   aeoi            automatic EOI on the trailing edge of the second INTA
//   vec_base[4:0]   T7..T3 of the returned vector
//   inta_n          synchronized CPU acknowledge (active low)
//   ocw2, ocw2_wr   OCW2 byte and its one-cycle write strobe
//   int_out         registered interrupt request to the CPU
//   vector, vector_valid  {vec_base,id}, valid during the second INTA
//   irr, isr        request / in-service registers
//   ack_state       00 IDLE, 01 ACK1, 11 ACK2
// Build option: define PIC_SFNM_EN to add the sfnm input (special fully
// nested mode: a request at the same level as the in-service top re-interrupts).
module pic_irq_scheduler
  import pic_pkg::*;
#(
  parameter logic [IR_ID_W-1:0] SPURIOUS_ID = 3'd7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IR-1:0]   ir,
  input  logic [NUM_IR-1:0]   imr,
  input  logic                ltim,
  input  logic                aeoi,
  input  logic [4:0]          vec_base,
  input  logic                inta_n,
  input  logic [7:0]          ocw2,
  input  logic                ocw2_wr,
`ifdef PIC_SFNM_EN
  input  logic                sfnm,
`endif
  output logic                int_out,
  output logic [7:0]          vector,
  output logic                vector_valid,
  output logic [NUM_IR-1:0]   irr,
  output logic [NUM_IR-1:0]   isr,
  output logic [1:0]          ack_state
);

  logic [NUM_IR-1:0]  ir_q, irr_q, irr_d, isr_q, isr_d;
  logic [IR_ID_W-1:0] lp_q, lp_d;
  logic               rot_aeoi_q, rot_aeoi_d;
  logic               inta_q;
  ack_state_e         state_q;
  logic [IR_ID_W-1:0] id_q;
  logic               id_real_q;   // id_q names a real IR, not the spurious fallback
  logic               int_q, vv_q;
  logic [7:0]         vector_q;

  // ---------------- priority resolution ----------------
  logic [NUM_IR-1:0]  masked_req;
  logic               cand_found, top_found;
  logic [IR_ID_W-1:0] cand_id, top_id;

  assign masked_req = irr_q & ~imr;

  pic_prio_find u_cand (.req_i(masked_req), .lp_i(lp_q), .found_o(cand_found), .id_o(cand_id));
  pic_prio_find u_top  (.req_i(isr_q),      .lp_i(lp_q), .found_o(top_found),  .id_o(top_id));

  // Rank 0 is the highest priority (the IR just after lp).
  logic [IR_ID_W-1:0] cand_rank, top_rank;
  logic               higher, req_valid;

  assign cand_rank = cand_id - lp_q - 3'd1;
  assign top_rank  = top_id  - lp_q - 3'd1;

`ifdef PIC_SFNM_EN
  assign higher = sfnm ? (cand_rank <= top_rank) : (cand_rank < top_rank);
`else
  assign higher = cand_rank < top_rank;
`endif

  assign req_valid = cand_found && (!top_found || higher);

  // ---------------- INTA edges and events ----------------
  logic inta_fall, inta_rise, ack_fire, aeoi_fire, next_idle;

  assign inta_fall = inta_q & ~inta_n;
  assign inta_rise = ~inta_q & inta_n;
  assign ack_fire  = (state_q == ST_IDLE) && inta_fall && req_valid;
  assign aeoi_fire = (state_q == ST_ACK2) && inta_rise && aeoi && id_real_q;
  assign next_idle = ((state_q == ST_IDLE) && !inta_fall) ||
                     ((state_q == ST_ACK2) && inta_rise);

  // ---------------- OCW2 decode ----------------
  logic [NUM_IR-1:0]  eoi_clr;
  logic               lp_ocw_we;
  logic [IR_ID_W-1:0] lp_ocw_val;
  logic [IR_ID_W-1:0] ocw_l;
  logic               unused_ocw2;

  assign ocw_l       = ocw2[2:0];
  assign unused_ocw2 = ^ocw2[4:3];

  always_comb begin
    eoi_clr    = '0;
    lp_ocw_we  = 1'b0;
    lp_ocw_val = '0;
    rot_aeoi_d = rot_aeoi_q;
    if (ocw2_wr) begin
      case (ocw2[7:5])
        NS_EOI: if (top_found) eoi_clr = id2mask(top_id);
        SP_EOI: eoi_clr = id2mask(ocw_l);
        ROT_NS_EOI: if (top_found) begin
          eoi_clr    = id2mask(top_id);
          lp_ocw_we  = 1'b1;
          lp_ocw_val = top_id;
        end
        ROT_SP_EOI: begin
          eoi_clr    = id2mask(ocw_l);
          lp_ocw_we  = 1'b1;
          lp_ocw_val = ocw_l;
        end
        SET_PRIO: begin
          lp_ocw_we  = 1'b1;
          lp_ocw_val = ocw_l;
        end
        ROT_AEOI_SET: rot_aeoi_d = 1'b1;
        ROT_AEOI_CLR: rot_aeoi_d = 1'b0;
        default: ;
      endcase
    end
  end

  // ---------------- IRR / ISR / lp next state ----------------
  logic [NUM_IR-1:0] ack_mask, aeoi_clr, edge_set;

  assign ack_mask = ack_fire  ? id2mask(cand_id) : '0;
  assign aeoi_clr = aeoi_fire ? id2mask(id_q)    : '0;
  assign edge_set = ir & ~ir_q;

  always_comb begin
    // A fresh edge re-sets a bit cleared by acknowledge; a held level does not.
    if (ltim) irr_d = ir & ~ack_mask;
    else      irr_d = ((irr_q & ~ack_mask) | edge_set) & ir;
    isr_d = (isr_q & ~eoi_clr & ~aeoi_clr) | ack_mask;
    // OCW2 rotation outranks AEOI rotation.
    if (lp_ocw_we)                   lp_d = lp_ocw_val;
    else if (aeoi_fire && rot_aeoi_q) lp_d = id_q;
    else                             lp_d = lp_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q       <= '0;
      irr_q      <= '0;
      isr_q      <= '0;
      lp_q       <= 3'd7;
      rot_aeoi_q <= 1'b0;
      inta_q     <= 1'b1;
    end else begin
      ir_q       <= ir;
      irr_q      <= irr_d;
      isr_q      <= isr_d;
      lp_q       <= lp_d;
      rot_aeoi_q <= rot_aeoi_d;
      inta_q     <= inta_n;
    end
  end

  // ---------------- INTA FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      id_real_q <= 1'b0;
      vector_q  <= '0;
      vv_q      <= 1'b0;
      int_q     <= 1'b0;
    end else begin
      int_q <= next_idle && req_valid;
      case (state_q)
        ST_IDLE: if (inta_fall) begin
          id_q      <= req_valid ? cand_id : SPURIOUS_ID;
          id_real_q <= req_valid;
          state_q   <= ST_ACK1;
        end
        ST_ACK1: if (inta_fall) begin
          vector_q <= {vec_base, id_q};
          vv_q     <= 1'b1;
          state_q  <= ST_ACK2;
        end
        ST_ACK2: if (inta_rise) begin
          vv_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign int_out      = int_q;
  assign vector       = vector_q;
  assign vector_valid = vv_q;
  assign irr          = irr_q;
  assign isr          = isr_q;
  assign ack_state    = state_q;

endmodule

// File: tb/tb_pic_irq_scheduler.sv
// Directed self-checking bench for pic_irq_scheduler.
module tb_pic_irq_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ir = '0, imr = '0, ocw2 = '0;
  logic       ltim = 1'b0, aeoi = 1'b0, inta_n = 1'b1, ocw2_wr = 1'b0;
  logic [4:0] vec_base = 5'h08;
`ifdef PIC_SFNM_EN
  logic       sfnm = 1'b0;
`endif
  logic       int_out, vector_valid;
  logic [7:0] vector, irr, isr;
  logic [1:0] ack_state;

  int checks = 0;
  int errors = 0;

  pic_irq_scheduler dut (
    .clk(clk), .rst(rst), .ir(ir), .imr(imr), .ltim(ltim), .aeoi(aeoi),
    .vec_base(vec_base), .inta_n(inta_n), .ocw2(ocw2), .ocw2_wr(ocw2_wr),
`ifdef PIC_SFNM_EN
    .sfnm(sfnm),
`endif
    .int_out(int_out), .vector(vector), .vector_valid(vector_valid),
    .irr(irr), .isr(isr), .ack_state(ack_state)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ir = '0; imr = '0; ltim = 1'b0; aeoi = 1'b0; inta_n = 1'b1;
    ocw2 = '0; ocw2_wr = 1'b0; vec_base = 5'h08;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic inta_pulse();
    inta_n = 1'b0; tick(1);
    inta_n = 1'b1; tick(1);
  endtask

  task automatic write_ocw2(input logic [7:0] v);
    ocw2 = v; ocw2_wr = 1'b1; tick(1);
    ocw2_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(2);
    checks++;
    if ({irr, isr, int_out, vector, vector_valid, ack_state} !== 29'h0) begin
      errors++;
      $display("FAIL reset_state got irr=%h isr=%h int=%b vec=%h vv=%b st=%b exp all zero",
               irr, isr, int_out, vector, vector_valid, ack_state);
    end
    rst = 1'b0; tick(1);
  endtask

  task automatic test_basic_ack();
    do_reset();
    ir = 8'h04; tick(3);
    checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL basic_int got %b exp 1", int_out); end
    checks++; if (irr !== 8'h04) begin errors++; $display("FAIL basic_irr got %h exp 04", irr); end
    inta_n = 1'b0; tick(1);
    checks++;
    if (ack_state !== 2'b01 || isr !== 8'h04 || irr !== 8'h00 || int_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack1 got st=%b isr=%h irr=%h int=%b exp 01/04/00/0", ack_state, isr, irr, int_out);
    end
    inta_n = 1'b1; tick(1);
    inta_n = 1'b0; tick(1);
    checks++;
    if (vector_valid !== 1'b1 || vector !== 8'h42 || ack_state !== 2'b11) begin
      errors++;
      $display("FAIL basic_vector got vv=%b vec=%h st=%b exp 1/42/11", vector_valid, vector, ack_state);
    end
    inta_n = 1'b1; tick(1);
    checks++;
    if (vector_valid !== 1'b0 || ack_state !== 2'b00 || isr !== 8'h04) begin
      errors++;
      $display("FAIL basic_done got vv=%b st=%b isr=%h exp 0/00/04", vector_valid, ack_state, isr);
    end
    ir = 8'h00;
  endtask

  task automatic test_nested_eoi();
    do_reset();
    ir = 8'h0A; tick(3);
    inta_pulse();
    inta_n = 1'b0; tick(1);
    checks++; if (vector !== 8'h41) begin errors++; $display("FAIL two_req_first got %h exp 41", vector); end
    inta_n = 1'b1; tick(2);
    checks++;
    if (isr !== 8'h02 || int_out !== 1'b0) begin
      errors++; $display("FAIL two_req_blocked got isr=%h int=%b exp 02/0", isr, int_out);
    end
    write_ocw2(8'h20);
    checks++; if (isr !== 8'h00) begin errors++; $display("FAIL ns_eoi got %h exp 00", isr); end
    tick(1);
    checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL second_int got %b exp 1", int_out); end
    inta_pulse();
    inta_n = 1'b0; tick(1);
    checks++; if (vector !== 8'h43) begin errors++; $display("FAIL second_vector got %h exp 43", vector); end
    inta_n = 1'b1; tick(1);
    checks++; if (isr !== 8'h08) begin errors++; $display("FAIL second_isr got %h exp 08", isr); end
  endtask

  // Relies on isr=0x08 left by test_nested_eoi.
  task automatic test_nesting();
    ir = 8'h00; tick(1);
    ir = 8'h20; tick(3);
    checks++;
    if (int_out !== 1'b0 || irr !== 8'h20) begin
      errors++; $display("FAIL lower_blocked got int=%b irr=%h exp 0/20", int_out, irr);
    end
    ir = 8'h22; tick(3);
    checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL higher_nests got %b exp 1", int_out); end
    inta_pulse();
    inta_n = 1'b0; tick(1);
    checks++; if (vector !== 8'h41) begin errors++; $display("FAIL nested_vector got %h exp 41", vector); end
    inta_n = 1'b1; tick(1);
    checks++; if (isr !== 8'h0A) begin errors++; $display("FAIL nested_isr got %h exp 0a", isr); end
    write_ocw2(8'h61);
    checks++; if (isr !== 8'h08) begin errors++; $display("FAIL sp_eoi got %h exp 08", isr); end
    ir = 8'h00; tick(1);
  endtask

  task automatic test_rotate();
    write_ocw2(8'hE3);
    checks++; if (isr !== 8'h00) begin errors++; $display("FAIL rot_sp_eoi got %h exp 00", isr); end
    ir = 8'h11; tick(3);
    inta_pulse();
    inta_n = 1'b0; tick(1);
    checks++; if (vector !== 8'h44) begin errors++; $display("FAIL rotated_vector got %h exp 44", vector); end
    inta_n = 1'b1; tick(1);
    ir = 8'h00;
    write_ocw2(8'h20);
    checks++; if (isr !== 8'h00) begin errors++; $display("FAIL rot_ns_clear got %h exp 00", isr); end
    write_ocw2(8'hC7);
    tick(1);
    ir = 8'h11; tick(3);
    inta_pulse();
    inta_n = 1'b0; tick(1);
    checks++; if (vector !== 8'h40) begin errors++; $display("FAIL set_prio_vector got %h exp 40", vector); end
    inta_n = 1'b1; tick(1);
    ir = 8'h00;
  endtask

  task automatic test_aeoi_spurious();
    do_reset();
    aeoi = 1'b1;
    ir = 8'h80; tick(3);
    inta_pulse();
    checks++; if (isr !== 8'h80) begin errors++; $display("FAIL aeoi_isr_set got %h exp 80", isr); end
    inta_n = 1'b0; tick(1);
    checks++; if (vector !== 8'h47) begin errors++; $display("FAIL aeoi_vector got %h exp 47", vector); end
    inta_n = 1'b1; tick(1);
    checks++; if (isr !== 8'h00) begin errors++; $display("FAIL aeoi_clear got %h exp 00", isr); end
    // Request withdrawn before the first INTA: spurious IR7.
    ir = 8'h00; tick(1);
    ir = 8'h80; tick(3);
    ir = 8'h00; tick(1);
    vec_base = 5'h10;
    inta_pulse();
    checks++;
    if (isr !== 8'h00 || ack_state !== 2'b01) begin
      errors++; $display("FAIL spurious_isr got isr=%h st=%b exp 00/01", isr, ack_state);
    end
    inta_n = 1'b0; tick(1);
    checks++; if (vector !== 8'h87) begin errors++; $display("FAIL spurious_vector got %h exp 87", vector); end
    inta_n = 1'b1; tick(1);
    // Rotate on AEOI: serving IR2 makes IR3 the highest.
    vec_base = 5'h08;
    write_ocw2(8'h80);
    ir = 8'h04; tick(3);
    inta_pulse(); inta_pulse();
    ir = 8'h00; tick(1);
    ir = 8'h0A; tick(3);
    inta_pulse();
    inta_n = 1'b0; tick(1);
    checks++; if (vector !== 8'h43) begin errors++; $display("FAIL aeoi_rotate_vector got %h exp 43", vector); end
    inta_n = 1'b1; tick(1);
    write_ocw2(8'h00);
    aeoi = 1'b0; ir = 8'h00;
  endtask

  task automatic test_level();
    do_reset();
    ltim = 1'b1;
    ir = 8'h40; tick(1);
    checks++; if (irr !== 8'h40) begin errors++; $display("FAIL level_follow got %h exp 40", irr); end
    ir = 8'h00; tick(1);
    checks++; if (irr !== 8'h00) begin errors++; $display("FAIL level_drop got %h exp 00", irr); end
    ltim = 1'b0;
  endtask

  task automatic test_reset_mid_ack();
    do_reset();
    ir = 8'h04; tick(3);
    inta_n = 1'b0; tick(1);
    checks++;
    if (ack_state !== 2'b01 || isr !== 8'h04) begin
      errors++; $display("FAIL pre_reset got st=%b isr=%h exp 01/04", ack_state, isr);
    end
    rst = 1'b1; tick(1);
    checks++;
    if (ack_state !== 2'b00 || isr !== 8'h00 || int_out !== 1'b0) begin
      errors++; $display("FAIL reset_mid_ack got st=%b isr=%h int=%b exp 00/00/0", ack_state, isr, int_out);
    end
    inta_n = 1'b1; ir = 8'h00; rst = 1'b0; tick(1);
  endtask

  initial begin
    test_reset();
    test_basic_ack();
    test_nested_eoi();
    test_nesting();
    test_rotate();
    test_aeoi_spurious();
    test_level();
    test_reset_mid_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
